fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the EX stage of the pipelined CPU. It tracks every in-flight register write in a shift pipeline of DEPTH post-EX stages, with a per-entry result latency. For each of NPORT EX-stage source operands it selects the youngest ready producer to forward from. It raises a stall when the youngest producer has not produced its result yet. It also counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit.sv | 76 +++++++
 tb/tb_fwd_hazard_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding select, load-use stall and stall counter
module fwd_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int NPORT = 2,
    parameter int DEPTH = 2,
    parameter int LAT_W = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    ex_valid_i,
    input  logic                    ex_regwrite_i,
    input  logic [ADDR_W-1:0]       ex_rd_i,
    input  logic [LAT_W-1:0]        ex_lat_i,
    input  logic [NPORT*ADDR_W-1:0] ex_rs_i,
    output logic [NPORT*SEL_W-1:0]  fwd_sel_o,
    output logic                    stall_o,
    output logic [15:0]             stall_cnt_o
);
    // index k holds stage k+1, so index 0 is EX/MEM
    logic              entValid [DEPTH];
    logic [ADDR_W-1:0] entRd    [DEPTH];
    logic [LAT_W-1:0]  entRem   [DEPTH];
    logic [NPORT-1:0]  hazVec;
    logic [LAT_W-1:0]  latClamp;
    // clamping keeps every producer ready before it leaves the last tracked stage
    assign latClamp = (32'(ex_lat_i) > DEPTH - 1) ? LAT_W'(DEPTH - 1) : ex_lat_i;
    assign stall_o = ex_valid_i && |hazVec;
    genvar p;
    generate
        for (p = 0; p < NPORT; p++) begin : g_port
            logic [ADDR_W-1:0] rs;
            logic [SEL_W-1:0]  sel;
            logic              haz;
            assign rs = ex_rs_i[p*ADDR_W +: ADDR_W];
            // scan oldest to youngest so the youngest match overwrites the result
            always_comb begin
                sel = '0;
                haz = 1'b0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (entValid[k] && entRd[k] == rs && rs != '0) begin
                        sel = SEL_W'(k + 1);
                        haz = entRem[k] != '0;
                    end
                end
            end
            assign fwd_sel_o[p*SEL_W +: SEL_W] = haz ? '0 : sel;
            assign hazVec[p] = haz;
        end
    endgenerate
    // shift the producer pipeline, aging latency as entries move down
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                entValid[k] <= 1'b0;
                entRd[k] <= '0;
                entRem[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entValid[k] <= !flush_i && entValid[k-1];
                entRd[k] <= entRd[k-1];
                entRem[k] <= entRem[k-1] != '0 ? entRem[k-1] - 1'b1 : '0;
            end
            entValid[0] <= !flush_i && ex_valid_i && !stall_o && ex_regwrite_i && ex_rd_i != '0;
            entRd[0] <= ex_rd_i;
            entRem[0] <= latClamp;
        end
    end
    // saturating stall-cycle counter; flushed stall cycles are not counted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_o <= '0;
        else if (stall_o && !flush_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects, stalls, flush, reset and counter saturation
module tb_fwd_hazard_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        exValid = 1'b0;
    logic        exRegwrite = 1'b0;
    logic [4:0]  exRd = '0;
    logic [1:0]  exLat = '0;
    logic [9:0]  exRs = '0;
    logic [3:0]  fwdSel;
    logic        stall;
    logic [15:0] stallCnt;
    logic        exValid2 = 1'b0;
    logic        exRegwrite2 = 1'b0;
    logic [4:0]  exRd2 = '0;
    logic [3:0]  exLat2 = '0;
    logic [4:0]  exRs2 = '0;
    logic [4:0]  fwdSel2;
    logic        stall2;
    logic [15:0] stallCnt2;
    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(exValid),
        .ex_regwrite_i(exRegwrite), .ex_rd_i(exRd), .ex_lat_i(exLat), .ex_rs_i(exRs),
        .fwd_sel_o(fwdSel), .stall_o(stall), .stall_cnt_o(stallCnt)
    );

    fwd_hazard_unit #(.ADDR_W(5), .NPORT(1), .DEPTH(16), .LAT_W(4)) dutDeep (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .ex_valid_i(exValid2),
        .ex_regwrite_i(exRegwrite2), .ex_rd_i(exRd2), .ex_lat_i(exLat2), .ex_rs_i(exRs2),
        .fwd_sel_o(fwdSel2), .stall_o(stall2), .stall_cnt_o(stallCnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic setEx(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] lat,
                         input logic [4:0] rs0, input logic [4:0] rs1);
        exValid = v;
        exRegwrite = rw;
        exRd = rd;
        exLat = lat;
        exRs = {rs1, rs0};
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_sel", 32'(fwdSel), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_cnt", 32'(stallCnt), 0);
        @(negedge clk) rst = 1'b0;
        // ALU back-to-back forwarding from stage 1 then stage 2
        setEx(1, 1, 3, 0, 0, 0);
        step();
        setEx(1, 0, 0, 0, 3, 0);
        check("alu_sel0", 32'(fwdSel[1:0]), 1);
        check("alu_stall", 32'(stall), 0);
        step();
        setEx(1, 0, 0, 0, 0, 3);
        check("alu_sel1", 32'(fwdSel[3:2]), 2);
        check("alu_sel0_none", 32'(fwdSel[1:0]), 0);
        step();
        // load-use: one stall cycle, then forward from stage 2
        setEx(1, 1, 5, 1, 0, 0);
        step();
        setEx(1, 0, 0, 0, 5, 0);
        check("lu_stall", 32'(stall), 1);
        check("lu_sel_haz", 32'(fwdSel[1:0]), 0);
        check("lu_cnt0", 32'(stallCnt), 0);
        step();
        #1;
        check("lu_stall_end", 32'(stall), 0);
        check("lu_sel2", 32'(fwdSel[1:0]), 2);
        check("lu_cnt1", 32'(stallCnt), 1);
        step();
        // youngest producer wins
        setEx(1, 1, 7, 0, 0, 0);
        step();
        setEx(1, 1, 7, 0, 0, 0);
        step();
        setEx(1, 0, 0, 0, 7, 7);
        check("young_sel0", 32'(fwdSel[1:0]), 1);
        check("young_sel1", 32'(fwdSel[3:2]), 1);
        check("young_stall", 32'(stall), 0);
        step();
        // youngest not ready stalls even though an older copy is ready
        setEx(1, 1, 8, 0, 0, 0);
        step();
        setEx(1, 1, 8, 1, 0, 0);
        step();
        setEx(1, 0, 0, 0, 8, 0);
        check("young_haz_stall", 32'(stall), 1);
        check("young_haz_sel", 32'(fwdSel[1:0]), 0);
        step();
        #1;
        check("young_haz_sel2", 32'(fwdSel[1:0]), 2);
        check("young_haz_cnt", 32'(stallCnt), 2);
        step();
        // zero register and non-writing instruction are never producers
        setEx(1, 1, 0, 0, 0, 0);
        step();
        setEx(1, 0, 4, 0, 0, 0);
        step();
        setEx(1, 0, 0, 0, 0, 4);
        check("zero_sel0", 32'(fwdSel[1:0]), 0);
        check("nowr_sel1", 32'(fwdSel[3:2]), 0);
        check("zero_stall", 32'(stall), 0);
        step();
        // invalid EX never stalls
        setEx(1, 1, 9, 1, 0, 0);
        step();
        setEx(0, 0, 0, 0, 9, 0);
        check("inv_stall", 32'(stall), 0);
        check("inv_sel", 32'(fwdSel[1:0]), 0);
        step();
        setEx(1, 0, 0, 0, 9, 0);
        check("inv_sel2", 32'(fwdSel[1:0]), 2);
        check("inv_cnt", 32'(stallCnt), 2);
        step();
        // latency 3 clamps to DEPTH-1 = 1
        setEx(1, 1, 10, 3, 0, 0);
        step();
        setEx(1, 0, 0, 0, 10, 0);
        check("clamp_stall", 32'(stall), 1);
        step();
        #1;
        check("clamp_stall_end", 32'(stall), 0);
        check("clamp_sel", 32'(fwdSel[1:0]), 2);
        check("clamp_cnt", 32'(stallCnt), 3);
        step();
        // flush during stall: not counted, entries cleared
        setEx(1, 1, 5, 1, 0, 0);
        step();
        setEx(1, 0, 0, 0, 5, 0);
        check("fl_stall_pre", 32'(stall), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("fl_stall", 32'(stall), 0);
        check("fl_sel", 32'(fwdSel[1:0]), 0);
        check("fl_cnt", 32'(stallCnt), 3);
        step();
        // asynchronous reset mid-stall
        setEx(1, 1, 6, 1, 0, 0);
        step();
        setEx(1, 0, 0, 0, 6, 0);
        check("mrst_pre", 32'(stall), 1);
        rst = 1'b1;
        #1;
        check("mrst_stall", 32'(stall), 0);
        check("mrst_sel", 32'(fwdSel), 0);
        check("mrst_cnt", 32'(stallCnt), 0);
        rst = 1'b0;
        #1;
        check("mrst_after", 32'(stall), 0);
        step();
        #1;
        check("mrst_next_sel", 32'(fwdSel[1:0]), 0);
        check("mrst_next_stall", 32'(stall), 0);
        setEx(0, 0, 0, 0, 0, 0);
        // deep instance: load r1 with latency 15 that also reads r1
        exValid2 = 1'b1;
        exRegwrite2 = 1'b1;
        exRd2 = 5'd1;
        exLat2 = 4'd15;
        exRs2 = 5'd1;
        #1;
        check("deep_first", 32'(stall2), 0);
        step();
        #1;
        check("deep_stall", 32'(stall2), 1);
        for (int i = 0; i < 15; i++) step();
        #1;
        check("deep_ready_stall", 32'(stall2), 0);
        check("deep_ready_sel", 32'(fwdSel2), 16);
        check("deep_cnt15", 32'(stallCnt2), 15);
        for (int i = 0; i < 16 * 4400; i++) step();
        check("deep_sat", 32'(stallCnt2), 32'hFFFF);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
